wrr_sched: RTL and testbench

Parametrised weighted round-robin scheduler: successor to the fixed three-queue round-robin selector. It arbitrates among N ready queues and gives each granted queue a burst of up to its programmable weight in consecutive transfers before rotating. Grants are presented on a valid/ack handshake, so a downstream consumer can stall the scheduler. The block sits between the per-queue ready flags and the shared output datapath mux.

---
 rtl/wrr_sched.sv | 106 ++++++++++
 tb/tb_wrr_sched.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/wrr_sched.sv
// wrr_sched: weighted round-robin scheduler over N ready queues.
// Each granted queue receives up to its weight in consecutive transfers
// before the grant rotates to the next eligible queue. The grant is held
// until the downstream consumer acks it. All outputs are registered, so
// q_rdy and ack reach the outputs only through a clock edge.
module wrr_sched #(
    parameter int N   = 4,
    parameter int WW  = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    q_rdy,
    input  logic [N*WW-1:0] q_wgt,
    input  logic            ack,
    output logic [N-1:0]    sel,
    output logic [IDW-1:0]  sel_id,
    output logic            sel_vld
);

    logic [IDW-1:0] last;
    logic [WW-1:0]  credit;

    logic [N-1:0]   elig;
    logic           xfer;
    logic           upd;
    logic           cont;
    logic           found;
    logic [IDW-1:0] hit;
    logic [IDW-1:0] idx;

    logic [N-1:0]   nxt_sel;
    logic [IDW-1:0] nxt_id;
    logic           nxt_vld;
    logic [IDW-1:0] nxt_last;
    logic [WW-1:0]  nxt_credit;

    // A queue is eligible when it has data and a non-zero weight.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            elig[i] = q_rdy[i] && (q_wgt[i*WW +: WW] != '0);
        end
    end

    // Search eligible queues starting just after the last grant, wrapping
    // so that the last granted queue is considered only after all others.
    always_comb begin
        found = 1'b0;
        hit   = '0;
        idx   = '0;
        for (int k = 1; k <= N; k++) begin
            idx = IDW'((int'(last) + k) % N);
            if (!found && elig[idx]) begin
                found = 1'b1;
                hit   = idx;
            end
        end
    end

    // Next grant: continue the current burst while credit remains, else
    // rotate and reload credit from the new queue's weight.
    always_comb begin
        xfer       = sel_vld && ack;
        upd        = !sel_vld || ack;
        cont       = xfer && (credit > WW'(1)) && elig[last];
        nxt_sel    = sel;
        nxt_id     = sel_id;
        nxt_vld    = sel_vld;
        nxt_last   = last;
        nxt_credit = credit;
        if (upd) begin
            if (cont) begin
                nxt_credit = credit - WW'(1);
            end else if (found) begin
                nxt_sel    = {{(N-1){1'b0}}, 1'b1} << hit;
                nxt_id     = hit;
                nxt_vld    = 1'b1;
                nxt_last   = hit;
                nxt_credit = q_wgt[int'(hit)*WW +: WW];
            end else begin
                nxt_sel = '0;
                nxt_id  = '0;
                nxt_vld = 1'b0;
            end
        end
    end

    // Grant, pointer and credit registers; reset points at N-1 so that
    // queue 0 has first priority after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel     <= '0;
            sel_id  <= '0;
            sel_vld <= 1'b0;
            last    <= IDW'(N - 1);
            credit  <= '0;
        end else begin
            sel     <= nxt_sel;
            sel_id  <= nxt_id;
            sel_vld <= nxt_vld;
            last    <= nxt_last;
            credit  <= nxt_credit;
        end
    end

endmodule

// File: tb/tb_wrr_sched.sv
// Directed bench for wrr_sched (N=4, WW=4): a table of per-cycle inputs and
// hand-computed grants, followed by an asynchronous mid-burst reset sequence.
module tb_wrr_sched;

    localparam int N   = 4;
    localparam int WW  = 4;
    localparam int IDW = 2;

    logic            clk;
    logic            rst;
    logic [N-1:0]    q_rdy;
    logic [N*WW-1:0] q_wgt;
    logic            ack;
    logic [N-1:0]    sel;
    logic [IDW-1:0]  sel_id;
    logic            sel_vld;

    int n_vec;
    int n_bad;

    typedef struct {
        logic [3:0]  rdy;
        logic [15:0] wgt;
        logic        ack;
        logic        vld;
        logic [1:0]  id;
    } vec_t;

    vec_t tbl[$];

    wrr_sched #(.N(N), .WW(WW)) dut (
        .clk     (clk),
        .rst     (rst),
        .q_rdy   (q_rdy),
        .q_wgt   (q_wgt),
        .ack     (ack),
        .sel     (sel),
        .sel_id  (sel_id),
        .sel_vld (sel_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic [3:0] r, input logic [15:0] w, input logic a,
                       input logic v, input logic [1:0] i);
        vec_t t;
        t.rdy = r; t.wgt = w; t.ack = a; t.vld = v; t.id = i;
        tbl.push_back(t);
    endtask

    task automatic check(input string name, input logic v, input logic [1:0] i);
        logic [3:0] es;
        logic [1:0] ei;
        es = v ? (4'b0001 << i) : 4'b0000;
        ei = v ? i : 2'd0;
        n_vec++;
        if (sel_vld !== v || sel_id !== ei || sel !== es) begin
            n_bad++;
            $display("FAIL %s: got vld=%b id=%0d sel=%b, want vld=%b id=%0d sel=%b",
                     name, sel_vld, sel_id, sel, v, ei, es);
        end
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst   = 1'b1;
        q_rdy = 4'b0000;
        q_wgt = 16'h1111;
        ack   = 1'b0;

        // plain round robin, weights all 1
        add(4'b1111, 16'h1111, 1, 1, 0);
        add(4'b1111, 16'h1111, 1, 1, 1);
        add(4'b1111, 16'h1111, 1, 1, 2);
        add(4'b1111, 16'h1111, 1, 1, 3);
        add(4'b1111, 16'h1111, 1, 1, 0);
        add(4'b1111, 16'h1111, 1, 1, 1);
        // weights q0=3 q1=1 q2=2 q3=1, entered while q1 is granted
        add(4'b1111, 16'h1213, 1, 1, 2);
        add(4'b1111, 16'h1213, 1, 1, 2);
        add(4'b1111, 16'h1213, 1, 1, 3);
        add(4'b1111, 16'h1213, 1, 1, 0);
        add(4'b1111, 16'h1213, 1, 1, 0);
        add(4'b1111, 16'h1213, 1, 1, 0);
        add(4'b1111, 16'h1213, 1, 1, 1);
        add(4'b1111, 16'h1213, 1, 1, 2);
        add(4'b1111, 16'h1213, 1, 1, 2);
        add(4'b1111, 16'h1213, 1, 1, 3);
        add(4'b1111, 16'h1213, 1, 1, 0);
        // q0 weight drops to 2 mid-burst: current burst keeps its credit of 3
        add(4'b1111, 16'h1112, 1, 1, 0);
        add(4'b1111, 16'h1112, 1, 1, 0);
        add(4'b1111, 16'h1112, 1, 1, 1);
        add(4'b1111, 16'h1112, 1, 1, 2);
        add(4'b1111, 16'h1112, 1, 1, 3);
        add(4'b1111, 16'h1112, 1, 1, 0);
        // backpressure on q0 (weight 2), sticky even when q0 ready drops
        add(4'b1111, 16'h1112, 0, 1, 0);
        add(4'b1110, 16'h1112, 0, 1, 0);
        add(4'b1111, 16'h1112, 0, 1, 0);
        add(4'b1111, 16'h1112, 1, 1, 0);
        add(4'b1111, 16'h1112, 1, 1, 1);
        // q0 weight 3 loses ready after one transfer
        add(4'b1111, 16'h1113, 1, 1, 2);
        add(4'b1111, 16'h1113, 1, 1, 3);
        add(4'b1111, 16'h1113, 1, 1, 0);
        add(4'b1110, 16'h1113, 1, 1, 1);
        // q2 masked by weight 0
        add(4'b1111, 16'h1011, 1, 1, 3);
        add(4'b1111, 16'h1011, 1, 1, 0);
        add(4'b1111, 16'h1011, 1, 1, 1);
        add(4'b1111, 16'h1011, 1, 1, 3);
        add(4'b0100, 16'h1011, 1, 0, 0);
        add(4'b0100, 16'h1011, 0, 0, 0);
        // single requester q2 weight 2, then idle
        add(4'b0100, 16'h1211, 1, 1, 2);
        add(4'b0100, 16'h1211, 1, 1, 2);
        add(4'b0100, 16'h1211, 1, 1, 2);
        add(4'b0100, 16'h1211, 1, 1, 2);
        add(4'b0000, 16'h1211, 1, 0, 0);
        add(4'b0000, 16'h1211, 0, 0, 0);
        // one-cycle latency from idle with ack low, then hold
        add(4'b0001, 16'h1111, 0, 1, 0);
        add(4'b0001, 16'h1111, 0, 1, 0);

        repeat (2) @(posedge clk);
        #1 check("reset_state", 1'b0, 2'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < tbl.size(); v++) begin
            q_rdy = tbl[v].rdy;
            q_wgt = tbl[v].wgt;
            ack   = tbl[v].ack;
            @(posedge clk);
            #1 check($sformatf("vec%0d", v), tbl[v].vld, tbl[v].id);
            @(negedge clk);
        end

        // mid-burst asynchronous reset
        q_rdy = 4'b1111;
        q_wgt = 16'h3333;
        ack   = 1'b1;
        @(posedge clk);
        #1 check("pre_rst_a", 1'b1, 2'd1);
        @(posedge clk);
        #1 check("pre_rst_b", 1'b1, 2'd1);
        #2 rst = 1'b1;
        #1 check("async_rst", 1'b0, 2'd0);
        @(posedge clk);
        #1 check("in_rst", 1'b0, 2'd0);
        @(negedge clk);
        rst   = 1'b0;
        q_wgt = 16'h1111;
        @(posedge clk);
        #1 check("post_rst_a", 1'b1, 2'd0);
        @(posedge clk);
        #1 check("post_rst_b", 1'b1, 2'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
